// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: walks FETCH/DECODE/EXEC/MEM/WB over the shared
// datapath and drives every strobe, mux select and the immediate-format select.
module rv32i_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [2:0]  ImmSel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_FENCE
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls;
  logic [OPC_W-1:0] opcode;
  logic             unused_instr;
  logic             mem_ack;

  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic       mem_addr_sel_q, mem_addr_sel_d;
  logic [1:0] alu_a_sel_q, alu_a_sel_d;
  logic       alu_b_sel_q, alu_b_sel_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       reg_write_q, reg_write_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       illegal_q, illegal_d;

  logic [2:0] imm_sel_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic [1:0] pc_src_c;

  assign opcode       = instr[OPC_W-1:0];
  assign unused_instr = ^instr[31:OPC_W];
  // mem_ready only counts while a request is actually outstanding
  assign mem_ack      = mem_req_q & mem_ready;

  always_comb begin
    cls = C_ILL;
    case (opcode)
      OPC_R:      cls = C_R;
      OPC_IALU:   cls = C_IALU;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_LUI:    cls = C_LUI;
      OPC_AUIPC:  cls = C_AUIPC;
      OPC_JAL:    cls = C_JAL;
      OPC_JALR:   cls = C_JALR;
      OPC_FENCE:  cls = C_FENCE;
      default:    cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_BRANCH, C_FENCE: state_d = S_FETCH;
          C_LOAD, C_STORE:   state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_ack) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Registered outputs are decoded from the state being entered, so they line up with it
  always_comb begin
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_sel_d = 1'b0;
    alu_a_sel_d    = 2'b00;
    alu_b_sel_d    = 1'b0;
    alu_op_d       = 2'b00;
    reg_write_d    = 1'b0;
    wb_sel_d       = 2'b00;
    illegal_d      = illegal_q | (state_d == S_TRAP);
    case (state_d)
      S_FETCH: mem_req_d = 1'b1;
      S_EXEC: begin
        case (cls)
          C_R:    alu_op_d = 2'b01;
          C_IALU: begin
            alu_b_sel_d = 1'b1;
            alu_op_d    = 2'b10;
          end
          C_LOAD, C_STORE, C_JALR: alu_b_sel_d = 1'b1;
          C_LUI: begin
            alu_a_sel_d = 2'b10;
            alu_b_sel_d = 1'b1;
          end
          C_AUIPC: begin
            alu_a_sel_d = 2'b01;
            alu_b_sel_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_d      = 1'b1;
        mem_addr_sel_d = 1'b1;
        mem_we_d       = (cls == C_STORE);
      end
      S_WB: begin
        reg_write_d = 1'b1;
        case (cls)
          C_LOAD:        wb_sel_d = 2'b01;
          C_JAL, C_JALR: wb_sel_d = 2'b10;
          default:       wb_sel_d = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_FETCH;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      alu_a_sel_q    <= 2'b00;
      alu_b_sel_q    <= 1'b0;
      alu_op_q       <= 2'b00;
      reg_write_q    <= 1'b0;
      wb_sel_q       <= 2'b00;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      alu_a_sel_q    <= alu_a_sel_d;
      alu_b_sel_q    <= alu_b_sel_d;
      alu_op_q       <= alu_op_d;
      reg_write_q    <= reg_write_d;
      wb_sel_q       <= wb_sel_d;
      illegal_q      <= illegal_d;
    end
  end

  // Immediate format follows the opcode for as long as the instruction is live
  always_comb begin
    imm_sel_c = 3'b000;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (cls)
        C_IALU, C_LOAD, C_JALR: imm_sel_c = 3'b001;
        C_STORE:                imm_sel_c = 3'b010;
        C_BRANCH:               imm_sel_c = 3'b011;
        C_LUI, C_AUIPC:         imm_sel_c = 3'b100;
        C_JAL:                  imm_sel_c = 3'b101;
        default:                imm_sel_c = 3'b000;
      endcase
    end
  end

  // Handshake- and branch-dependent strobes must act in the same cycle as their trigger
  always_comb begin
    ir_write_c = (state_q == S_FETCH) & mem_ack;
    pc_write_c = 1'b0;
    pc_src_c   = 2'b00;
    case (state_q)
      S_EXEC: begin
        if (cls == C_BRANCH) begin
          pc_write_c = 1'b1;
          pc_src_c   = br_taken ? 2'b01 : 2'b00;
        end else if (cls == C_FENCE) begin
          pc_write_c = 1'b1;
        end
      end
      S_MEM: pc_write_c = (cls == C_STORE) & mem_ack;
      S_WB: begin
        pc_write_c = 1'b1;
        case (cls)
          C_JAL:   pc_src_c = 2'b01;
          C_JALR:  pc_src_c = 2'b10;
          default: pc_src_c = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign ImmSel       = imm_sel_c;
  assign ir_write     = ir_write_c;
  assign pc_write     = pc_write_c;
  assign pc_src       = pc_src_c;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr_sel = mem_addr_sel_q;
  assign alu_a_sel    = alu_a_sel_q;
  assign alu_b_sel    = alu_b_sel_q;
  assign alu_op       = alu_op_q;
  assign reg_write    = reg_write_q;
  assign wb_sel       = wb_sel_q;
  assign illegal      = illegal_q;

endmodule

// File: doc/rv32i_multicycle_ctrl.md
# rv32i_multicycle_ctrl

Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath (ALU, register file, single memory port, immediate extender). It drives every datapath strobe and mux select, including the 3-bit `ImmSel` consumed by the immediate extender.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  32  instruction-register contents; stable from DECODE onward.
- `mem_ready`  in  1  memory-port acknowledge for the current `mem_req`.
- `br_taken`  in  1  branch comparator result; valid in EXEC.
- `ImmSel`  out  3  immediate format select:
  - 000 none, 001 I, 010 S, 011 B, 100 U, 101 J.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  update the PC.
- `pc_src`  out  2  PC source: 00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store enable.
- `mem_addr_sel`  out  1  memory address: 0 PC, 1 ALU result register.
- `alu_a_sel`  out  2  ALU A operand: 00 rs1, 01 PC, 10 zero.
- `alu_b_sel`  out  1  ALU B operand: 0 rs2, 1 immediate.
- `alu_op`  out  2  ALU operation: 00 add, 01 R-type funct decode, 10 I-type funct decode.
- `reg_write`  out  1  register-file write enable.
- `wb_sel`  out  2  writeback source: 00 ALU, 01 memory data, 10 PC+4.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States and transitions:
  - FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On `mem_ready`, pulse `ir_write` and go to DECODE.
  - DECODE: classify `instr[6:0]`; the register file reads. Unknown opcode or 1110011 goes to TRAP; every other opcode goes to EXEC.
  - EXEC: depends on instruction class (below).
  - MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores only. On `mem_ready`, a load goes to WB; a store pulses pc_write with pc_src=00 and goes to FETCH.
  - WB: reg_write=1 and pc_write=1 with the class pc_src, then go to FETCH.
  - TRAP: all strobes 0, `illegal`=1. Held until `rst`.
- EXEC by opcode:
  - R-type 0110011: alu_a_sel=00, alu_b_sel=0, alu_op=01 -> WB (wb_sel 00, pc_src 00).
  - I-ALU 0010011: rs1 + imm, alu_op=10 -> WB.
  - LOAD 0000011: rs1 + imm, alu_op=00 -> MEM, then WB with wb_sel 01.
  - STORE 0100011: rs1 + imm -> MEM.
  - BRANCH 1100011: pc_write=1, pc_src = br_taken ? 01 : 00 -> FETCH.
  - LUI 0110111: zero + imm -> WB.
  - AUIPC 0010111: PC + imm -> WB.
  - JAL 1101111: -> WB with wb_sel 10, pc_src 01.
  - JALR 1100111: rs1 + imm -> WB with wb_sel 10, pc_src 10.
  - FENCE 0001111: pc_write with pc_src 00 -> FETCH. No register write.
- `ImmSel` is combinational from `instr[6:0]` in DECODE, EXEC, MEM and WB:
  - 001 for I-ALU, LOAD and JALR.
  - 010 for STORE.
  - 011 for BRANCH.
  - 100 for LUI and AUIPC.
  - 101 for JAL.
  - 000 for R-type, FENCE, and in FETCH and TRAP.
- Any strobe not listed for a state is 0. Select outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH and `illegal`=0. All outputs are 0 except mem_req, which is 1 one cycle after reset release because FETCH asserts it.
- `rst` asserted mid-instruction aborts immediately. mem_req drops asynchronously and no pc_write or reg_write occurs; the memory side must tolerate a dropped request.
- Handshake:
  - `mem_ready` is sampled at the rising edge only while mem_req=1; it is ignored otherwise.
  - mem_req, mem_we and mem_addr_sel hold stable until accepted.
  - Any number of wait cycles is allowed.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle):
  - BRANCH and FENCE: 3 cycles.
  - R-type, I-ALU, LUI, AUIPC, JAL, JALR and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `ir_write` is asserted exactly 1 cycle per instruction. `pc_write` is asserted exactly 1 cycle per retired instruction and never in TRAP.
- `ImmSel` is stable from DECODE until leaving the last state of the instruction.

## Test plan
- ADDI x1,x0,5 (0x00500093), mem_ready tied to 1:
  - DECODE: ImmSel=001.
  - EXEC: alu_b_sel=1, alu_op=10.
  - WB at cycle 4: reg_write=1, pc_src=00.
  - Back in FETCH at cycle 5.
- SW x2,8(x1) (0x0020A423) with mem_ready delayed 3 cycles in MEM:
  - ImmSel=010.
  - mem_we=1 held for 4 cycles.
  - pc_write only after ack.
  - No reg_write.
- BEQ (0x00208463):
  - ImmSel=011.
  - br_taken=1 gives pc_src=01; br_taken=0 gives pc_src=00.
  - pc_write in cycle 3.
- JAL x1,+16 (0x010000EF):
  - ImmSel=101.
  - WB: wb_sel=10, pc_src=01, reg_write=1.
- LUI (0x123450B7) gives ImmSel=100, alu_a_sel=10. Opcode 0x7F gives TRAP with illegal=1, staying there for 20 cycles.
- `rst` pulsed during MEM of a LOAD with mem_req=1:
  - Outputs clear immediately; reg_write is never asserted.
  - FETCH resumes after reset release with illegal=0.
